// File: rtl/operand_loader_if.sv
// Operand bus from the loader to the add/sub stage.
// Carries the captured operands, operation select and the valid flag.
// No backpressure: the consumer samples whenever valid is high.
interface operand_loader_if;
  logic [7:0] ina;
  logic [7:0] inb;
  logic       mode;
  logic       valid;

  // Loader side drives the operands.
  modport master (output ina, output inb, output mode, output valid);

  // Adder side only observes them.
  modport slave (input ina, input inb, input mode, input valid);
endinterface

// File: rtl/operand_loader.sv
// Captures operand A, then operand B plus mode, from switches on debounced key presses.
// Latency: key_n fall at edge t -> press at t+3+DEBOUNCE_CYCLES -> capture at t+4+DEBOUNCE_CYCLES.
// No backpressure: outputs hold until the next accepted press; the consumer samples at will.
module operand_loader #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [7:0]          sw,
  input  logic                mode_sw,
  input  logic                key_n,
  operand_loader_if.master    bus,
  output logic [1:0]          state,
  output logic                press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT_A = 2'b00,
    WAIT_B = 2'b01,
    READY  = 2'b10,
    UNUSED = 2'b11
  } state_t;

  // Synchronizer, debounce and edge-detect state.
  logic             key_m;
  logic             key_s;
  logic             key_db;
  logic             key_db_q;
  logic [CNT_W-1:0] cnt;

  // FSM and capture registers.
  state_t     state_q;
  state_t     state_d;
  logic       load_a;
  logic       load_b;
  logic       valid_c;
  logic [7:0] ina_q;
  logic [7:0] inb_q;
  logic       mode_q;

  // Two-flop synchronizer; idles high so a released key reads as not pressed.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      key_m <= 1'b1;
      key_s <= 1'b1;
    end else begin
      key_m <= key_n;
      key_s <= key_m;
    end
  end

  // Accept a new key level only after DEBOUNCE_CYCLES consecutive differing samples;
  // any sample matching the current level restarts the count.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      key_db <= 1'b1;
      cnt    <= '0;
    end else if (key_s == key_db) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      key_db <= key_s;
      cnt    <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // One-cycle pulse on the debounced falling edge only; release and hold give nothing.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      key_db_q <= 1'b1;
      press    <= 1'b0;
    end else begin
      key_db_q <= key_db;
      press    <= key_db_q & ~key_db;
    end
  end

  // FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= WAIT_A;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: advance only on accepted presses; the spare encoding recovers to WAIT_A.
  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_A:  if (press) state_d = WAIT_B;
      WAIT_B:  if (press) state_d = READY;
      READY:   if (press) state_d = WAIT_B;
      default: state_d = WAIT_A;
    endcase
  end

  // Output decode: which operand to load this cycle, and whether the pair is complete.
  // A press in READY loads a fresh A so a new calculation starts immediately.
  always_comb begin
    load_a  = 1'b0;
    load_b  = 1'b0;
    valid_c = 1'b0;
    case (state_q)
      WAIT_A:  load_a = press;
      WAIT_B:  load_b = press;
      READY: begin
        valid_c = 1'b1;
        load_a  = press;
      end
      default: begin
        load_a  = 1'b0;
        load_b  = 1'b0;
        valid_c = 1'b0;
      end
    endcase
  end

  // Operand capture; switch values are sampled only on the press cycle edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ina_q  <= 8'h00;
      inb_q  <= 8'h00;
      mode_q <= 1'b0;
    end else begin
      if (load_a) begin
        ina_q <= sw;
      end
      if (load_b) begin
        inb_q  <= sw;
        mode_q <= mode_sw;
      end
    end
  end

  assign bus.ina   = ina_q;
  assign bus.inb   = inb_q;
  assign bus.mode  = mode_q;
  assign bus.valid = valid_c;
  assign state     = state_q;

endmodule

// File: tb/tb_operand_loader.sv
// Directed bench for operand_loader with a short debounce window.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
// Press pulses are counted on the falling edge.
module tb_operand_loader;
  localparam int DB = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] sw = 8'h00;
  logic       mode_sw = 1'b0;
  logic       key_n = 1'b1;
  logic [1:0] state;
  logic       press;

  operand_loader_if bus ();

  operand_loader #(.DEBOUNCE_CYCLES(DB)) dut (
    .clock   (clock),
    .reset   (reset),
    .sw      (sw),
    .mode_sw (mode_sw),
    .key_n   (key_n),
    .bus     (bus.master),
    .state   (state),
    .press   (press)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;
  int press_cnt = 0;
  int base;

  // Count accepted presses while out of reset.
  always @(negedge clock) begin
    if (reset && press) press_cnt <= press_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Clean press: hold low, then release and let the debouncer settle.
  task automatic do_press(input int hold);
    key_n = 1'b0;
    tick(hold);
    key_n = 1'b1;
    tick(DB + 6);
  endtask

  // Toggle key_n every 2 cycles for 20 cycles, starting from the given level.
  task automatic bounce(input logic start);
    for (int i = 0; i < 10; i++) begin
      key_n = (i % 2 == 0) ? start : ~start;
      tick(2);
    end
  endtask

  initial begin
    // Reset held with key pressed and switches all ones.
    reset = 1'b0; key_n = 1'b0; sw = 8'hFF;
    tick(3);
    check("rst_ina",   32'(bus.ina),   32'h00);
    check("rst_inb",   32'(bus.inb),   32'h00);
    check("rst_mode",  32'(bus.mode),  32'h0);
    check("rst_valid", 32'(bus.valid), 32'h0);
    check("rst_state", 32'(state),     32'h0);
    check("rst_press", 32'(press),     32'h0);

    // Release reset with key held: press exactly 7 cycles later.
    reset = 1'b1;
    tick(6);
    check("held_press_early", 32'(press), 32'h0);
    tick(1);
    check("held_press_at7", 32'(press), 32'h1);
    tick(10);
    check("held_press_count", 32'(press_cnt), 32'd1);
    check("held_ina", 32'(bus.ina), 32'hFF);
    check("held_state", 32'(state), 32'h1);
    key_n = 1'b1;
    tick(DB + 6);

    // Asynchronous reset in WAIT_B, mid-cycle, no edge needed.
    #2 reset = 1'b0;
    #1;
    check("async_state", 32'(state),     32'h0);
    check("async_ina",   32'(bus.ina),   32'h00);
    check("async_valid", 32'(bus.valid), 32'h0);
    tick(1);
    reset = 1'b1;
    tick(2);

    // Clean press with latency check; sw changes on the press cycle.
    sw = 8'hAA;
    base = press_cnt;
    key_n = 1'b0;               // falls at edge t
    tick(DB + 2);               // edge t+6
    check("lat_press_t6", 32'(press), 32'h0);
    tick(1);                    // edge t+7
    check("lat_press_t7", 32'(press), 32'h1);
    check("lat_ina_t7", 32'(bus.ina), 32'h00);
    sw = 8'h25;                 // sampled at the capture edge
    tick(1);                    // edge t+8
    check("lat_ina_t8",   32'(bus.ina),   32'h25);
    check("lat_state_t8", 32'(state),     32'h1);
    check("lat_valid_t8", 32'(bus.valid), 32'h0);
    check("lat_press_t8", 32'(press),     32'h0);
    tick(4);
    key_n = 1'b1;
    tick(DB + 6);

    // Second press captures B and mode.
    sw = 8'h3C; mode_sw = 1'b1;
    do_press(10);
    check("b_inb",   32'(bus.inb),   32'h3C);
    check("b_mode",  32'(bus.mode),  32'h1);
    check("b_valid", 32'(bus.valid), 32'h1);
    check("b_state", 32'(state),     32'h2);
    check("b_ina",   32'(bus.ina),   32'h25);

    // Switch sweep without presses leaves outputs alone.
    for (int v = 0; v < 256; v++) begin
      sw = 8'(v);
      mode_sw = v[0];
      tick(1);
    end
    check("sweep_ina",   32'(bus.ina),   32'h25);
    check("sweep_inb",   32'(bus.inb),   32'h3C);
    check("sweep_mode",  32'(bus.mode),  32'h1);
    check("sweep_state", 32'(state),     32'h2);
    check("sweep_press", 32'(press_cnt - base), 32'd2);

    // READY re-entry loads a new A and drops valid.
    sw = 8'h7F;
    do_press(10);
    check("re_ina",   32'(bus.ina),   32'h7F);
    check("re_inb",   32'(bus.inb),   32'h3C);
    check("re_valid", 32'(bus.valid), 32'h0);
    check("re_state", 32'(state),     32'h1);

    // Bouncy press and release: a single capture of B.
    base = press_cnt;
    sw = 8'h11; mode_sw = 1'b0;
    bounce(1'b0);
    key_n = 1'b0;
    tick(20);
    bounce(1'b1);
    key_n = 1'b1;
    tick(20);
    check("bnc_press_cnt", 32'(press_cnt - base), 32'd1);
    check("bnc_inb",   32'(bus.inb),   32'h11);
    check("bnc_mode",  32'(bus.mode),  32'h0);
    check("bnc_state", 32'(state),     32'h2);
    check("bnc_valid", 32'(bus.valid), 32'h1);

    // Long hold: one press, one state step.
    base = press_cnt;
    sw = 8'h99;
    do_press(100);
    check("hold_press_cnt", 32'(press_cnt - base), 32'd1);
    check("hold_ina",   32'(bus.ina), 32'h99);
    check("hold_state", 32'(state),   32'h1);

    // Reset in the middle of a debounce.
    key_n = 1'b0;
    tick(3);
    reset = 1'b0;
    #1;
    check("mid_state", 32'(state),   32'h0);
    check("mid_ina",   32'(bus.ina), 32'h00);
    check("mid_inb",   32'(bus.inb), 32'h00);
    key_n = 1'b1;
    tick(2);
    reset = 1'b1;
    base = press_cnt;
    tick(DB + 6);
    check("mid_no_press", 32'(press_cnt - base), 32'd0);
    check("mid_state_after", 32'(state), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
